// File: rtl/rand_digit_arbiter.sv
// Round-robin shared decimal digit source: 16-bit Galois LFSR with bounded rejection
// sampling to 0..9 and a deterministic fallback digit when the try budget runs out.
module rand_digit_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_TRY = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             SEED_LD,
    input  logic [15:0]      SEED_IN,
    output logic [N_REQ-1:0] GNT,
    output logic             VALID,
    output logic [3:0]       DIGIT,
    output logic             BUSY,
    output logic [7:0]       REJECT_CNT
);
    localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned TW  = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic [TW-1:0]    try_q, try_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       digit_q, digit_d;
    logic             busy_q, busy_d;
    logic [7:0]       rej_q, rej_d;

    logic [15:0]      lfsr_next;
    logic [3:0]       cand;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      pos;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    assign cand      = lfsr_next[3:0];

    // Round-robin search starting one past the last granted requester, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            pos = {1'b0, ptr_q} + PW1'(i);
            if (pos >= PW1'(N_REQ)) begin
                pos = pos - PW1'(N_REQ);
            end
            if (!win_found && REQ[pos[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        try_d    = try_q;
        digit_d  = digit_q;
        rej_d    = rej_q;

        unique case (state_q)
            StIdle: begin
                if (SEED_LD) begin
                    lfsr_d = (SEED_IN == 16'h0000) ? SEED : SEED_IN;
                end
                if (win_found) begin
                    winner_d = win_idx;
                    try_d    = '0;
                    state_d  = StDraw;
                end
            end
            StDraw: begin
                lfsr_d = lfsr_next;
                if (cand <= 4'd9) begin
                    digit_d = cand;
                    state_d = StDone;
                end else begin
                    if (rej_q != 8'hFF) begin
                        rej_d = rej_q + 8'd1;
                    end
                    if (try_q == TRY_LAST) begin
                        digit_d = cand - 4'd10;
                        state_d = StDone;
                    end else begin
                        try_d = try_q + TW'(1);
                    end
                end
            end
            StDone: begin
                ptr_d   = winner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        valid_d = (state_d == StDone);
        busy_d  = (state_d != StIdle);
        gnt_d   = valid_d ? (N_REQ'(1) << winner_d) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            lfsr_q   <= SEED;
            ptr_q    <= PTR_RST;
            winner_q <= '0;
            try_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            digit_q  <= 4'd0;
            busy_q   <= 1'b0;
            rej_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            try_q    <= try_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            digit_q  <= digit_d;
            busy_q   <= busy_d;
            rej_q    <= rej_d;
        end
    end

    assign GNT        = gnt_q;
    assign VALID      = valid_q;
    assign DIGIT      = digit_q;
    assign BUSY       = busy_q;
    assign REJECT_CNT = rej_q;

endmodule
